// File: rtl/alu_fifo_sequencer_pkg.sv
// alu_fifo_sequencer_pkg: ALU opcode constants and the sequencer FSM state encoding
package alu_fifo_sequencer_pkg;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, PUSH} state_t;
endpackage

// File: rtl/alu_fifo_sequencer_if.sv
// alu_fifo_sequencer_if: RX FIFO, ALU and TX FIFO signals plus status of the sequencer
// rx_empty/rx_data/rx_read: first-word-fall-through RX FIFO head and pop strobe
// alu_a/alu_b/alu_op/alu_result: registered operands to, and combinational result from, the ALU
// tx_full/tx_write/tx_data: TX FIFO push side; busy/frames: sequencer status
interface alu_fifo_sequencer_if #(
  parameter int WORD = 8,
  parameter int OP_W = 6,
  parameter int CNT_W = 8
);
  logic rx_empty;
  logic [WORD-1:0] rx_data;
  logic rx_read;
  logic [WORD-1:0] alu_a;
  logic [WORD-1:0] alu_b;
  logic [OP_W-1:0] alu_op;
  logic [WORD-1:0] alu_result;
  logic tx_full;
  logic tx_write;
  logic [WORD-1:0] tx_data;
  logic busy;
  logic [CNT_W-1:0] frames;
  modport master (
    input rx_empty, rx_data, alu_result, tx_full,
    output rx_read, alu_a, alu_b, alu_op, tx_write, tx_data, busy, frames
  );
  modport slave (
    output rx_empty, rx_data, alu_result, tx_full,
    input rx_read, alu_a, alu_b, alu_op, tx_write, tx_data, busy, frames
  );
endinterface

// File: rtl/alu_fifo_sequencer.sv
// alu_fifo_sequencer: pops A, B, opcode from the RX FIFO, runs the external ALU and pushes the result to the TX FIFO
// i_clock: rising-edge clock; i_reset: synchronous active-high reset
// bus: master side of alu_fifo_sequencer_if (RX pop, ALU operands, TX push, busy, frames)
module alu_fifo_sequencer
  import alu_fifo_sequencer_pkg::*;
#(
  parameter int WORD = 8,
  parameter int OP_W = 6,
  parameter int CNT_W = 8
) (
  input logic i_clock,
  input logic i_reset,
  alu_fifo_sequencer_if.master bus
);
  state_t state, state_nx;
  logic get;
  // Strobes are gated by reset so nothing is popped or pushed in a reset cycle.
  always_comb begin
    get = state == GET_A || state == GET_B || state == GET_OP;
    bus.rx_read = !i_reset && get && !bus.rx_empty;
    bus.tx_write = !i_reset && state == PUSH && !bus.tx_full;
    bus.busy = state != GET_A;
    state_nx = bus.rx_read ? (state == GET_A ? GET_B : state == GET_B ? GET_OP : EXEC) :
               state == EXEC ? PUSH :
               bus.tx_write ? GET_A : state;
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= GET_A;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.alu_op <= '0;
      bus.tx_data <= '0;
      bus.frames <= '0;
    end else begin
      state <= state_nx;
      if (bus.rx_read && state == GET_A) bus.alu_a <= bus.rx_data;
      if (bus.rx_read && state == GET_B) bus.alu_b <= bus.rx_data;
      if (bus.rx_read && state == GET_OP) bus.alu_op <= bus.rx_data[OP_W-1:0];
      if (state == EXEC) bus.tx_data <= bus.alu_result;
      if (bus.tx_write) bus.frames <= bus.frames + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_fifo_sequencer.sv
// tb_alu_fifo_sequencer: directed frames against a queue-modelled RX FIFO and a behavioural ALU
module tb_alu_fifo_sequencer;
  import alu_fifo_sequencer_pkg::*;
  logic clk = 0;
  logic rst = 1;
  int n_pass = 0;
  int n_chk = 0;
  int cyc = 0;
  logic [7:0] rxq[$];
  logic [7:0] push_dat[$];
  int pop_cyc[$];
  int push_cyc[$];
  alu_fifo_sequencer_if bus();
  alu_fifo_sequencer dut (.i_clock(clk), .i_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_AND: return a & b;
      OP_OR: return a | b;
      OP_XOR: return a ^ b;
      OP_NOR: return ~(a | b);
      OP_SRA: return $signed(a) >>> b;
      OP_SRL: return a >> b;
      default: return 8'h00;
    endcase
  endfunction
  always_comb bus.alu_result = alu(bus.alu_a, bus.alu_b, bus.alu_op);
  always @(negedge clk) begin
    bus.rx_empty = rxq.size() == 0;
    bus.rx_data = rxq.size() == 0 ? 8'h00 : rxq[0];
  end
  always @(posedge clk) begin
    if (bus.rx_read) begin
      pop_cyc.push_back(cyc);
      if (rxq.size() > 0) void'(rxq.pop_front());
    end
    if (bus.tx_write) begin
      push_cyc.push_back(cyc);
      push_dat.push_back(bus.tx_data);
    end
    cyc++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic clear();
    pop_cyc.delete();
    push_cyc.delete();
    push_dat.delete();
  endtask
  task automatic do_reset();
    rst = 1;
    tick(2);
    rst = 0;
  endtask
  function automatic logic [7:0] last_push();
    return push_dat.size() > 0 ? push_dat[push_dat.size()-1] : 8'hxx;
  endfunction
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal;
  end
  initial begin
    int k;
    bus.tx_full = 0;
    tick(3);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_frames", bus.frames, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_state", dut.state, GET_A);
    rst = 0;
    clear();
    rxq.push_back(8'h05); rxq.push_back(8'h03); rxq.push_back(8'h20);
    tick(8);
    check("t1_pops", pop_cyc.size(), 3);
    check("t1_pop_span", pop_cyc.size() == 3 ? pop_cyc[2] - pop_cyc[0] : -1, 2);
    check("t1_pushes", push_cyc.size(), 1);
    check("t1_latency", push_cyc.size() == 1 && pop_cyc.size() > 0 ? push_cyc[0] - pop_cyc[0] : -1, 4);
    check("t1_data", last_push(), 8'h08);
    check("t1_frames", bus.frames, 1);
    check("t1_ops", {bus.alu_a, bus.alu_b, 2'b00, bus.alu_op}, 24'h050320);
    check("t1_idle", bus.busy, 0);
    clear();
    rxq.push_back(8'h03);
    tick(22);
    check("t2_pops_gap", pop_cyc.size(), 1);
    check("t2_state", dut.state, GET_B);
    check("t2_busy", bus.busy, 1);
    @(negedge clk); #1;
    check("t2_no_pop_empty", bus.rx_read, 0);
    rxq.push_back(8'h05);
    tick(2);
    rxq.push_back(8'h22);
    tick(8);
    check("t2_pops", pop_cyc.size(), 3);
    check("t2_pushes", push_cyc.size(), 1);
    check("t2_data", last_push(), 8'hFE);
    check("t2_frames", bus.frames, 2);
    clear();
    bus.tx_full = 1;
    rxq.push_back(8'hF0); rxq.push_back(8'h0F); rxq.push_back(8'h26);
    rxq.push_back(8'h01); rxq.push_back(8'h02); rxq.push_back(8'h20);
    k = 0;
    while (dut.state != PUSH && k < 12) begin tick(1); k++; end
    check("t3_reach_push", dut.state, PUSH);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t3_hold_data", bus.tx_data, 8'hFF);
    end
    check("t3_no_push_full", push_cyc.size(), 0);
    check("t3_no_pop_full", pop_cyc.size(), 3);
    bus.tx_full = 0;
    tick(12);
    check("t3_pushes", push_cyc.size(), 2);
    check("t3_data0", push_dat.size() > 0 ? push_dat[0] : 8'hxx, 8'hFF);
    check("t3_data1", last_push(), 8'h03);
    check("t3_frames", bus.frames, 4);
    clear();
    rxq.push_back(8'h11); rxq.push_back(8'h22);
    tick(4);
    rst = 1;
    rxq.push_back(8'h0C);
    @(negedge clk); #1;
    check("t4_no_pop_rst", bus.rx_read, 0);
    check("t4_no_push_rst", bus.tx_write, 0);
    tick(1);
    rst = 0;
    check("t4_pops_rst", pop_cyc.size(), 2);
    check("t4_state", dut.state, GET_A);
    check("t4_regs", {bus.alu_a, bus.alu_b, 2'b00, bus.alu_op, bus.tx_data}, 0);
    check("t4_frames", bus.frames, 0);
    rxq.push_back(8'h0A); rxq.push_back(8'h24);
    tick(8);
    check("t4_data", last_push(), 8'h08);
    check("t4_alu_a", bus.alu_a, 8'h0C);
    check("t4_frames_after", bus.frames, 1);
    do_reset();
    clear();
    rxq.push_back(8'h01); rxq.push_back(8'h01); rxq.push_back(8'h20);
    rxq.push_back(8'h80); rxq.push_back(8'h01); rxq.push_back(8'h03);
    tick(14);
    check("t5_pushes", push_cyc.size(), 2);
    check("t5_data0", push_dat.size() > 0 ? push_dat[0] : 8'hxx, 8'h02);
    check("t5_data1", last_push(), 8'hC0);
    check("t5_spacing", push_cyc.size() == 2 ? push_cyc[1] - push_cyc[0] : -1, 5);
    check("t5_frames", bus.frames, 2);
    do_reset();
    clear();
    for (int i = 0; i < 255; i++) begin
      rxq.push_back(8'(i)); rxq.push_back(8'h01); rxq.push_back({2'b00, OP_ADD});
    end
    k = 0;
    while (bus.frames != 8'd255 && k < 1400) begin tick(1); k++; end
    check("t6_frames_255", bus.frames, 255);
    check("t6_pushes", push_cyc.size(), 255);
    check("t6_data_255", last_push(), 8'hFF);
    rxq.push_back(8'hFF); rxq.push_back(8'h01); rxq.push_back({2'b11, OP_ADD});
    tick(8);
    check("t6_frames_wrap", bus.frames, 0);
    check("t6_data_wrap", last_push(), 8'h00);
    check("t6_op_low_bits", bus.alu_op, OP_ADD);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_fifo_sequencer.md
Name: alu_fifo_sequencer

Overview:
Controller between the UART RX FIFO, the ALU and the UART TX FIFO.
- Pops three bytes per frame from the RX FIFO: operand A, operand B, opcode.
- Drives the external combinational ALU, registers the result and pushes it into the TX FIFO.
- Sole reader of the RX FIFO and sole writer of the TX FIFO; frames are handled strictly in order.

Parameters:
WORD, 8, data width of FIFOs, operands and result
OP_W, 6, opcode width (taken from the low OP_W bits of the third byte)
CNT_W, 8, width of the completed-frame counter

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_rx_empty  in  1  RX FIFO empty flag
i_rx_data  in  WORD  RX FIFO head word, valid whenever i_rx_empty=0 (first-word-fall-through)
o_rx_read  out  1  RX FIFO pop strobe, head consumed at the same rising edge
o_alu_a  out  WORD  registered operand A to ALU
o_alu_b  out  WORD  registered operand B to ALU
o_alu_op  out  OP_W  registered opcode to ALU
i_alu_result  in  WORD  ALU combinational result
i_tx_full  in  1  TX FIFO full flag
o_tx_write  out  1  TX FIFO push strobe
o_tx_data  out  WORD  registered result presented to TX FIFO
o_busy  out  1  high whenever state is not GET_A
o_frames  out  CNT_W  count of results pushed, wraps modulo 2^CNT_W

Behaviour:
- Reset (i_clock edge with i_reset=1):
  - state=GET_A.
  - o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_frames all cleared to 0.
  - Partial frame discarded.
  - o_rx_read and o_tx_write forced 0 while i_reset=1.
- FSM states: GET_A, GET_B, GET_OP, EXEC, PUSH.
- GET_A / GET_B / GET_OP:
  - o_rx_read = !i_rx_empty (combinational).
  - On an edge with o_rx_read=1, latch i_rx_data into A / B / op[OP_W-1:0] and advance to the next state.
  - If empty, hold state and register; never pop an empty FIFO.
- EXEC: one cycle.
  - o_alu_* are stable.
  - Latch i_alu_result into o_tx_data and go to PUSH.
- PUSH:
  - o_tx_write = !i_tx_full (combinational).
  - On an edge with o_tx_write=1: o_frames+1, go to GET_A.
  - While i_tx_full=1, hold PUSH; o_tx_data is held stable.
- Latency: with bytes available, pops occur in cycles n, n+1, n+2; EXEC is cycle n+3; o_tx_write is asserted in cycle n+4. The next frame's first pop is no earlier than n+5.
- No validation of the opcode; unknown codes pass through and the ALU defines the result.
- The opcode byte's upper WORD-OP_W bits are ignored.
- Operands are never modified after latching until the next frame overwrites them.
- Reset mid-frame: no pop or push occurs in the reset cycle. The next frame restarts at GET_A; bytes already popped are lost.
- Simultaneous RX empty→non-empty and TX full: independent. RX is only sampled in the GET states, TX only in PUSH.

Decomposition:
- Shared package: opcode constants.
  - ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, NOR=6'b100111, SRA=6'b000011, SRL=6'b000010.
  - The FSM state encoding, shared with the benches.
- No sub-module; the ALU stays external and is wired at the top level.

Test Plan:
- RX holds 0x05,0x03,0x20 back-to-back, TX not full → o_rx_read high for exactly 3 cycles; o_tx_write one cycle at n+4 with o_tx_data=0x08; o_frames=1.
- Bytes 0x03, then 0x05 after a 20-cycle gap, then 0x22 → no pop while empty; state held in GET_B; result 0xFE pushed after the opcode arrives.
- Frame 0xF0,0x0F,0x26 with i_tx_full=1 for 10 cycles after EXEC → o_tx_write low and o_tx_data=0xFF held throughout; single push when full drops; no RX pop meanwhile.
- i_reset pulsed after A and B are popped (0x11,0x22) → outputs zero, state GET_A; next frame 0x0C,0x0A,0x24 yields 0x08.
- Two frames queued (0x01,0x01,0x20 then 0x80,0x01,0x03) → pushes 0x02 then 0xC0 in order; o_frames=2.
- o_frames preset to 255 via 255 frames, then one more frame → o_frames wraps to 0.
